// File: rtl/btn_pulse_gen.sv
// Push-button front end: two-flop synchroniser, press/release debounce and
// single-cycle enable pulses (one per press, optional auto-repeat while held).
module btn_pulse_gen #(
    parameter int DB_CYCLES   = 1000000,
    parameter int REPEAT_EN   = 0,
    parameter int HOLD_CYCLES = 50000000,
    parameter int RATE_CYCLES = 10000000
) (
    input  logic clk,
    input  logic RST_N,
    input  logic BTN,
    output logic EN,
    output logic BTN_DB
);

    localparam int MAX_A = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int MAX_C = (MAX_A > RATE_CYCLES) ? MAX_A : RATE_CYCLES;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] DB_TERM   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RATE_TERM = CNT_W'(RATE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        DB_RELEASE = 3'd4
    } state_t;

    logic             s1_reg;
    logic             s2_reg;
    logic             btn_s;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign btn_s = s2_reg;

    // One counter is shared by debounce, hold delay and repeat rate; every
    // state transition clears it, so it never runs past its terminal value.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            EN        <= 1'b0;
            BTN_DB    <= 1'b0;
        end else begin
            s1_reg <= BTN;
            s2_reg <= s1_reg;
            EN     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (btn_s) begin
                        state_reg <= DB_PRESS;
                        cnt_reg   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!btn_s) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == DB_TERM) begin
                        state_reg <= HELD;
                        cnt_reg   <= '0;
                        EN        <= 1'b1;
                        BTN_DB    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_reg <= DB_RELEASE;
                        cnt_reg   <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (cnt_reg == HOLD_TERM) begin
                            state_reg <= REPEAT;
                            cnt_reg   <= '0;
                            EN        <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                REPEAT: begin
                    if (!btn_s) begin
                        state_reg <= DB_RELEASE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == RATE_TERM) begin
                        cnt_reg <= '0;
                        EN      <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DB_RELEASE: begin
                    // A release glitch drops back to HELD and restarts the hold timer.
                    if (btn_s) begin
                        state_reg <= HELD;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == DB_TERM) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        BTN_DB    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: a single-pulse and an auto-repeat instance share one
// button; a run-length/anchor-time reference model predicts EN and BTN_DB each cycle.
module tb_btn_pulse_gen;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RATE = 3;

    logic clk   = 1'b0;
    logic RST_N = 1'b0;
    logic BTN   = 1'b0;
    logic en0, db0, en1, db1;

    btn_pulse_gen #(
        .DB_CYCLES(DB), .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .RATE_CYCLES(RATE)
    ) dut_single (
        .clk(clk), .RST_N(RST_N), .BTN(BTN), .EN(en0), .BTN_DB(db0)
    );

    btn_pulse_gen #(
        .DB_CYCLES(DB), .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .RATE_CYCLES(RATE)
    ) dut_repeat (
        .clk(clk), .RST_N(RST_N), .BTN(BTN), .EN(en1), .BTN_DB(db1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at t=%0t", tag, got, exp, $time);
    endtask

    // Reference model: synchroniser as a 2-entry delay line; the debounced
    // level flips after DB+1 consecutive synced samples disagreeing with it;
    // repeat pulses fall at anchor+HOLD, anchor+HOLD+RATE, ... where the
    // anchor is the press pulse or the return from a rejected release glitch.
    bit m_s1, m_s2;
    bit m_db[2];
    int m_run[2];
    int m_anchor[2];
    bit m_en[2];
    bit m_rep[2] = '{1'b0, 1'b1};
    int m_edge;

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_edge = 0;
        for (int i = 0; i < 2; i++) begin
            m_db[i] = 1'b0; m_run[i] = 0; m_anchor[i] = 0; m_en[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit bs;
        int n;
        if (!RST_N) begin
            model_reset();
            return;
        end
        bs = m_s2;
        m_s2 = m_s1;
        m_s1 = BTN;
        m_edge++;
        for (int i = 0; i < 2; i++) begin
            m_en[i] = 1'b0;
            if (!m_db[i]) begin
                if (bs) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_db[i] = 1'b1; m_run[i] = 0; m_en[i] = 1'b1; m_anchor[i] = m_edge;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else if (bs) begin
                if (m_run[i] > 0) m_anchor[i] = m_edge;
                m_run[i] = 0;
                n = m_edge - m_anchor[i];
                if (m_rep[i] && (n == HOLD || (n > HOLD && (n - HOLD) % RATE == 0)))
                    m_en[i] = 1'b1;
            end else begin
                m_run[i]++;
                if (m_run[i] == DB + 1) begin
                    m_db[i] = 1'b0; m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit b);
        BTN = b;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("en_single", en0, m_en[0]);
        check("db_single", db0, m_db[0]);
        check("en_repeat", en1, m_en[1]);
        check("db_repeat", db1, m_db[1]);
    endtask

    task automatic hold(input string tag, input bit b, input int n);
        $display("seg %-10s btn=%0b len=%0d edge=%0d", tag, b, n, m_edge);
        for (int i = 0; i < n; i++) cyc(b);
    endtask

    initial begin
        model_reset();
        hold("reset", 1'b0, 3);
        RST_N = 1'b1;
        hold("idle", 1'b0, 4);

        // Clean press; single instance pulses once, repeat instance keeps going.
        hold("press", 1'b1, 30);
        hold("release", 1'b0, 12);

        // Press bounce: bursts shorter than the debounce window.
        for (int r = 0; r < 5; r++) begin
            hold("bounce_hi", 1'b1, 3);
            hold("bounce_lo", 1'b0, 2);
        end
        hold("settle", 1'b0, 10);

        hold("autorep", 1'b1, 40);
        hold("release", 1'b0, 12);

        // Release glitch while held, then a real release.
        hold("held", 1'b1, 12);
        hold("glitch_lo", 1'b0, 2);
        hold("held", 1'b1, 15);
        hold("release", 1'b0, 12);

        // Widths around the minimum accepted press.
        hold("narrow4", 1'b1, 4);
        hold("release", 1'b0, 12);
        hold("narrow5", 1'b1, 5);
        hold("release", 1'b0, 12);

        for (int s = 0; s < 200; s++)
            hold("random", 1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        hold("release", 1'b0, 12);

        // Async reset in the middle of auto-repeat, right on a pulse cycle.
        hold("to_repeat", 1'b1, 20);
        for (int i = 0; i < 20 && !m_en[1]; i++) cyc(1'b1);
        check("repeat_pulse_seen", en1, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        check("rst_async_en", en1, 1'b0);
        check("rst_async_db_single", db0, 1'b0);
        check("rst_async_db_repeat", db1, 1'b0);
        model_reset();
        hold("in_reset", 1'b1, 3);
        RST_N = 1'b1;
        hold("post_reset", 1'b1, 20);
        hold("release", 1'b0, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
